sne_sram_burst_ctrl: RTL and testbench



---
 rtl/sne_sram_ctrl_pkg.sv | 36 +++
 rtl/sne_sram_rd_buf.sv | 72 +++++++
 rtl/sne_sram_burst_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_sne_sram_burst_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sne_sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sne_sram_ctrl_pkg
//  Description : Shared types and constants for the SNE SRAM burst
//                controller: FSM state encoding, latched command record and
//                read-buffer geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package sne_sram_ctrl_pkg;

    // Read-return buffer depth; two entries cover the one-cycle macro latency
    // while still sustaining one word per cycle.
    localparam int C_RD_BUF_DEPTH = 2;
    localparam int C_RD_OCC_W     = $clog2(C_RD_BUF_DEPTH + 1);

    // Command fields are held at a fixed width; address depths up to 2^16.
    localparam int C_CMD_FIELD_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_SLEEP = 3'd4,
        ST_WAKE  = 3'd5
    } ctrl_state_e;

    // Latched burst command; addr and len advance as beats are issued.
    typedef struct packed {
        logic                     we;
        logic [C_CMD_FIELD_W-1:0] addr;
        logic [C_CMD_FIELD_W-1:0] len;
    } sne_cmd_t;

endpackage
`default_nettype wire

// File: rtl/sne_sram_rd_buf.sv
`default_nettype none
// ============================================================================
//  Module      : sne_sram_rd_buf
//  Description : Two-entry synchronous FIFO catching SRAM read data, with
//                occupancy output and synchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module sne_sram_rd_buf
    import sne_sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  clr_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [C_RD_OCC_W-1:0] occ_o
);

    // Single-bit pointers: the buffer is exactly two entries deep.
    logic [DATA_WIDTH-1:0] mem_q [C_RD_BUF_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [C_RD_BUF_DEPTH];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [C_RD_OCC_W-1:0] occ_q, occ_d;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign w_do_pop  = pop_i && (occ_q != '0);
    assign w_do_push = push_i && ((occ_q != C_RD_OCC_W'(C_RD_BUF_DEPTH)) || w_do_pop);
    assign data_o    = mem_q[rd_ptr_q];
    assign occ_o     = occ_q;

    // Next-state: write at wr_ptr, advance pointers, track occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (w_do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (w_do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({w_do_push, w_do_pop})
            2'b10:   occ_d = occ_q + C_RD_OCC_W'(1);
            2'b01:   occ_d = occ_q - C_RD_OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Storage and pointer registers with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sne_sram_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sne_sram_burst_ctrl
//  Description : Read/write burst initiator for the single-port sne_sram
//                macro. Issues one word per cycle, absorbs the one-cycle read
//                latency in a 2-entry buffer, and optionally sleeps the macro
//                when idle.
//  Options     : SNE_SRAM_SLEEP_EN - enables idle counter, SLEEP/WAKE states
//                and mem_power_sleep_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module sne_sram_burst_ctrl
    import sne_sram_ctrl_pkg::*;
#(
    parameter int  DATA_WIDTH        = 8,
    parameter int  NUM_WORDS         = 32,
    parameter int  IDLE_SLEEP_CYCLES = 16,
    localparam int ADDR_WIDTH        = $clog2(NUM_WORDS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [ADDR_WIDTH-1:0] cmd_len_i,
    input  logic                  wdata_valid_i,
    output logic                  wdata_ready_o,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DATA_WIDTH-1:0] wbe_i,
    output logic                  rdata_valid_o,
    input  logic                  rdata_ready_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  done_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [DATA_WIDTH-1:0] mem_be_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  mem_power_gate_o,
    output logic                  mem_power_sleep_o
);

    ctrl_state_e              state_q, state_d;
    sne_cmd_t                 cmd_q, cmd_d;
    logic                     inflight_q, inflight_d;
    logic                     done_q, done_d;
    logic [C_RD_OCC_W-1:0]    w_occ;
    logic                     w_pop;
    logic [2:0]               w_outstanding;
    logic                     w_rd_credit;
    logic [C_CMD_FIELD_W-1:0] w_addr_next;

`ifdef SNE_SRAM_SLEEP_EN
    localparam int C_IDLE_CNT_W = $clog2(IDLE_SLEEP_CYCLES + 1);
    logic [C_IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
`endif

    // Address wraps at the last word, also for non-power-of-two depths.
    assign w_addr_next = (cmd_q.addr == C_CMD_FIELD_W'(NUM_WORDS - 1))
                       ? '0 : cmd_q.addr + C_CMD_FIELD_W'(1);

    // Words buffered plus in flight, after this cycle's pop.
    assign w_pop         = rdata_valid_o & rdata_ready_i;
    assign w_outstanding = 3'(w_occ) + 3'(inflight_q) - 3'(w_pop);
    assign w_rd_credit   = w_outstanding < 3'(C_RD_BUF_DEPTH);

    assign rdata_valid_o    = (w_occ != '0);
    assign done_o           = done_q;
    assign mem_addr_o       = cmd_q.addr[ADDR_WIDTH-1:0];
    assign mem_power_gate_o = 1'b0;

`ifdef SNE_SRAM_SLEEP_EN
    assign mem_power_sleep_o = (state_q == ST_SLEEP);
`else
    assign mem_power_sleep_o = 1'b0;
`endif

    // Next-state, command bookkeeping and SRAM port drive.
    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        inflight_d    = 1'b0;
        done_d        = 1'b0;
        cmd_ready_o   = 1'b0;
        wdata_ready_o = 1'b0;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        mem_wdata_o   = '0;
        mem_be_o      = '0;
`ifdef SNE_SRAM_SLEEP_EN
        idle_cnt_d    = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    cmd_d.we   = cmd_we_i;
                    cmd_d.addr = C_CMD_FIELD_W'(cmd_addr_i);
                    cmd_d.len  = C_CMD_FIELD_W'(cmd_len_i);
                    state_d    = cmd_we_i ? ST_WRITE : ST_READ;
                end
`ifdef SNE_SRAM_SLEEP_EN
                else if (w_occ == '0) begin
                    if (idle_cnt_q == C_IDLE_CNT_W'(IDLE_SLEEP_CYCLES - 1)) begin
                        state_d = ST_SLEEP;
                    end else begin
                        idle_cnt_d = idle_cnt_q + C_IDLE_CNT_W'(1);
                    end
                end
`endif
            end
            ST_WRITE: begin
                wdata_ready_o = 1'b1;
                if (wdata_valid_i) begin
                    mem_req_o   = 1'b1;
                    mem_we_o    = cmd_q.we;
                    mem_wdata_o = wdata_i;
                    mem_be_o    = wbe_i;
                    cmd_d.addr  = w_addr_next;
                    cmd_d.len   = cmd_q.len - C_CMD_FIELD_W'(1);
                    if (cmd_q.len == '0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (w_rd_credit) begin
                    mem_req_o  = 1'b1;
                    mem_we_o   = cmd_q.we;
                    inflight_d = 1'b1;
                    cmd_d.addr = w_addr_next;
                    cmd_d.len  = cmd_q.len - C_CMD_FIELD_W'(1);
                    if (cmd_q.len == '0) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // The last word lands in the buffer while inflight is high.
                if (!inflight_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
`ifdef SNE_SRAM_SLEEP_EN
            ST_SLEEP: begin
                if (cmd_valid_i) begin
                    state_d = ST_WAKE;
                end
            end
            ST_WAKE: begin
                state_d = ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers; reset abandons any burst in progress.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef SNE_SRAM_SLEEP_EN
            idle_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
`ifdef SNE_SRAM_SLEEP_EN
            idle_cnt_q <= idle_cnt_d;
`endif
        end
    end

    sne_sram_rd_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_buf (
        .clk_i  (clk_i),
        .clr_i  (rst_i),
        .push_i (inflight_q),
        .data_i (mem_rdata_i),
        .pop_i  (w_pop),
        .data_o (rdata_o),
        .occ_o  (w_occ)
    );

endmodule
`default_nettype wire

// File: tb/tb_sne_sram_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sne_sram_burst_ctrl
//  Description : Directed self-checking bench for sne_sram_burst_ctrl with a
//                behavioural SRAM and a read-data scoreboard.
//  Options     : SNE_SRAM_SLEEP_EN - adds the idle sleep / wake sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sne_sram_burst_ctrl;

    localparam int DW = 8;
    localparam int NW = 32;
    localparam int AW = 5;

    logic          clk         = 1'b0;
    logic          rst         = 1'b1;
    logic          cmd_valid   = 1'b0;
    logic          cmd_we      = 1'b0;
    logic [AW-1:0] cmd_addr    = '0;
    logic [AW-1:0] cmd_len     = '0;
    logic          wdata_valid = 1'b0;
    logic [DW-1:0] wdata       = '0;
    logic [DW-1:0] wbe         = '0;
    logic          rdata_ready = 1'b0;
    logic [DW-1:0] mem_rdata   = '0;

    logic          cmd_ready_o;
    logic          wdata_ready_o;
    logic          rdata_valid_o;
    logic [DW-1:0] rdata_o;
    logic          done_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_be_o;
    logic          mem_power_gate_o;
    logic          mem_power_sleep_o;

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] exp_mem [NW];
    logic [DW-1:0] sram    [NW];
    logic [DW-1:0] sb [$];
    int            obs_addr [$];
    logic [DW-1:0] last_rdata;

    always #5 clk = ~clk;

    sne_sram_burst_ctrl #(
        .DATA_WIDTH        (DW),
        .NUM_WORDS         (NW),
        .IDLE_SLEEP_CYCLES (16)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .cmd_valid_i       (cmd_valid),
        .cmd_ready_o       (cmd_ready_o),
        .cmd_we_i          (cmd_we),
        .cmd_addr_i        (cmd_addr),
        .cmd_len_i         (cmd_len),
        .wdata_valid_i     (wdata_valid),
        .wdata_ready_o     (wdata_ready_o),
        .wdata_i           (wdata),
        .wbe_i             (wbe),
        .rdata_valid_o     (rdata_valid_o),
        .rdata_ready_i     (rdata_ready),
        .rdata_o           (rdata_o),
        .done_o            (done_o),
        .mem_req_o         (mem_req_o),
        .mem_we_o          (mem_we_o),
        .mem_addr_o        (mem_addr_o),
        .mem_wdata_o       (mem_wdata_o),
        .mem_be_o          (mem_be_o),
        .mem_rdata_i       (mem_rdata),
        .mem_power_gate_o  (mem_power_gate_o),
        .mem_power_sleep_o (mem_power_sleep_o)
    );

    // Behavioural single-port SRAM with bit enables and 1-cycle read latency.
    always @(posedge clk) begin
        if (mem_req_o && mem_we_o) begin
            sram[mem_addr_o] <= (sram[mem_addr_o] & ~mem_be_o) | (mem_wdata_o & mem_be_o);
        end
        if (mem_req_o && !mem_we_o) begin
            mem_rdata <= sram[mem_addr_o];
        end else begin
            mem_rdata <= 'x;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!cmd_ready_o && n < 100) begin
            tick();
            n++;
        end
        check("cmd_ready_wait", 32'(cmd_ready_o), 32'd1);
    endtask

    task automatic send_cmd(input logic we, input int addr, input int len);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = AW'(addr);
        cmd_len   = AW'(len);
        tick();
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
    endtask

    task automatic write_burst(input int addr, input int len, input logic [DW-1:0] d[$],
                               input logic [DW-1:0] be[$], input string tag);
        int a;
        send_cmd(1'b1, addr, len);
        a = addr;
        obs_addr.delete();
        for (int i = 0; i <= len; i++) begin
            wdata_valid = 1'b1;
            wdata       = d[i];
            wbe         = be[i];
            exp_mem[a]  = (exp_mem[a] & ~be[i]) | (d[i] & be[i]);
            @(negedge clk);
            obs_addr.push_back(int'(mem_addr_o));
            check({tag, "_wready"}, 32'(wdata_ready_o), 32'd1);
            check({tag, "_req_we"}, 32'({mem_req_o, mem_we_o}), 32'd3);
            check({tag, "_addr"}, 32'(mem_addr_o), 32'(a));
            check({tag, "_wdata"}, 32'(mem_wdata_o), 32'(d[i]));
            check({tag, "_be"}, 32'(mem_be_o), 32'(be[i]));
            tick();
            a = (a == NW - 1) ? 0 : a + 1;
        end
        wdata_valid = 1'b0;
        @(negedge clk);
        check({tag, "_done"}, 32'(done_o), 32'd1);
        check({tag, "_ready_in_done"}, 32'(cmd_ready_o), 32'd1);
        tick();
        @(negedge clk);
        check({tag, "_done_single"}, 32'(done_o), 32'd0);
    endtask

    task automatic push_expected(input int addr, input int len);
        int a;
        a = addr;
        for (int i = 0; i <= len; i++) begin
            sb.push_back(exp_mem[a]);
            a = (a == NW - 1) ? 0 : a + 1;
        end
    endtask

    // Runs from the first cycle after command acceptance; mode 1 toggles ready.
    task automatic read_run(input int addr, input int len, input int mode, input bit timing,
                            input string tag, input int stop_after);
        int exp_a, issued, delivered, dones, k;
        bit pop;
        logic [DW-1:0] exp_d;
        exp_a = addr; issued = 0; delivered = 0; dones = 0; k = 1;
        while ((delivered < len + 1 || dones == 0) && k < 200 &&
               !(stop_after > 0 && delivered >= stop_after)) begin
            rdata_ready = (mode == 0) ? 1'b1 : 1'(k % 2);
            @(negedge clk);
            pop = rdata_valid_o && rdata_ready;
            if (mem_req_o) begin
                check({tag, "_credit"}, 32'((issued - delivered - int'(pop)) < 2), 32'd1);
                check({tag, "_no_extra_req"}, 32'(issued < len + 1), 32'd1);
                check({tag, "_raddr"}, 32'(mem_addr_o), 32'(exp_a));
                check({tag, "_rd_we"}, 32'(mem_we_o), 32'd0);
                exp_a = (exp_a == NW - 1) ? 0 : exp_a + 1;
                issued++;
            end
            if (pop) begin
                check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    exp_d = sb.pop_front();
                    check({tag, "_rdata"}, 32'(rdata_o), 32'(exp_d));
                end
                if (timing) begin
                    check({tag, "_rdata_cycle"}, 32'(k), 32'(3 + delivered));
                end
                last_rdata = rdata_o;
                delivered++;
            end
            if (done_o) begin
                dones++;
                check({tag, "_done_count"}, 32'(dones), 32'd1);
            end
            tick();
            k++;
        end
        rdata_ready = 1'b0;
        if (stop_after == 0) begin
            check({tag, "_delivered"}, 32'(delivered), 32'(len + 1));
            check({tag, "_dones"}, 32'(dones), 32'd1);
        end
    endtask

    task automatic read_burst(input int addr, input int len, input int mode, input bit timing,
                              input string tag, input int stop_after);
        push_expected(addr, len);
        send_cmd(1'b0, addr, len);
        read_run(addr, len, mode, timing, tag, stop_after);
    endtask

    // Watchdog so a stuck DUT still terminates the run.
    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Directed test sequence.
    initial begin
        logic [DW-1:0] d [$];
        logic [DW-1:0] be [$];

        for (int i = 0; i < NW; i++) exp_mem[i] = '0;

        // Reset state.
        rst = 1'b1;
        tick(); tick(); tick();
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("rst_rdata_valid", 32'(rdata_valid_o), 32'd0);
        check("rst_mem_req", 32'(mem_req_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_wdata_ready", 32'(wdata_ready_o), 32'd0);
        check("rst_power_gate", 32'(mem_power_gate_o), 32'd0);
        check("rst_power_sleep", 32'(mem_power_sleep_o), 32'd0);
        rst = 1'b0;
        tick();

        // Basic write then read-back with latency check.
        d.delete(); be.delete();
        for (int i = 0; i < 4; i++) begin
            d.push_back(DW'(8'hA1 + i));
            be.push_back(8'hFF);
        end
        write_burst(4, 3, d, be, "wr_basic");
        read_burst(4, 3, 0, 1'b1, "rd_basic", 0);
        check("rd_basic_last", 32'(last_rdata), 32'hA4);

        // Address wrap at the end of the array.
        d.delete(); be.delete();
        for (int i = 0; i < 4; i++) begin
            d.push_back(DW'(8'h30 + i));
            be.push_back(8'hFF);
        end
        write_burst(30, 3, d, be, "wr_wrap");
        check("wrap_addr0", 32'(obs_addr[0]), 32'd30);
        check("wrap_addr1", 32'(obs_addr[1]), 32'd31);
        check("wrap_addr2", 32'(obs_addr[2]), 32'd0);
        check("wrap_addr3", 32'(obs_addr[3]), 32'd1);
        read_burst(30, 3, 0, 1'b0, "rd_wrap", 0);

        // Backpressure with toggling ready.
        d.delete(); be.delete();
        for (int i = 0; i < 8; i++) begin
            d.push_back(DW'(8'h5C + 7 * i));
            be.push_back(8'hFF);
        end
        write_burst(8, 7, d, be, "wr_bp");
        read_burst(8, 7, 1, 1'b0, "rd_bp", 0);

        // Bit enables: lower nibble cleared, upper nibble kept.
        d.delete(); be.delete();
        d.push_back(8'hFF); be.push_back(8'hFF);
        write_burst(20, 0, d, be, "wr_be_full");
        d.delete(); be.delete();
        d.push_back(8'h00); be.push_back(8'h0F);
        write_burst(20, 0, d, be, "wr_be_low");
        read_burst(20, 0, 0, 1'b0, "rd_be", 0);
        check("rd_be_value", 32'(last_rdata), 32'hF0);

        // Reset in the middle of a read burst.
        read_burst(8, 7, 0, 1'b0, "rd_abort", 2);
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("midrst_rdata_valid", 32'(rdata_valid_o), 32'd0);
        check("midrst_mem_req", 32'(mem_req_o), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("midrst_done", 32'(done_o), 32'd0);
        rst = 1'b0;
        sb.delete();
        tick();
        read_burst(8, 3, 0, 1'b1, "rd_post_rst", 0);

`ifdef SNE_SRAM_SLEEP_EN
        // Idle sleep entry and wake-up latency.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        @(negedge clk);
        check("sleep_before", 32'(mem_power_sleep_o), 32'd0);
        tick();
        @(negedge clk);
        check("sleep_entered", 32'(mem_power_sleep_o), 32'd1);
        check("sleep_cmd_ready", 32'(cmd_ready_o), 32'd0);
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_addr  = AW'(20);
        cmd_len   = AW'(0);
        tick();
        @(negedge clk);
        check("wake_sleep_low", 32'(mem_power_sleep_o), 32'd0);
        check("wake_cmd_ready", 32'(cmd_ready_o), 32'd0);
        tick();
        @(negedge clk);
        check("wake_accept", 32'(cmd_ready_o), 32'd1);
        push_expected(20, 0);
        tick();
        cmd_valid = 1'b0;
        read_run(20, 0, 0, 1'b1, "rd_wake", 0);
        check("rd_wake_value", 32'(last_rdata), 32'hF0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
